pwm_sweep_ctrl: RTL and testbench

PWM_SWEEP_CTRL -- requirements
Module: pwm_sweep_ctrl

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_wrap_detect.sv | 27 ++
 rtl/pwm_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_pwm_sweep_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM duty sweep controller: FSM states and config
// register addresses.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      UP   = 2'd2,
      DOWN = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_LO    = 2'd0;
   localparam logic [1:0] ADDR_HI    = 2'd1;
   localparam logic [1:0] ADDR_STEP  = 2'd2;
   localparam logic [1:0] ADDR_DWELL = 2'd3;

endpackage

// File: rtl/pwm_wrap_detect.sv
// PWM period boundary detector: the phase accumulator wrapping shows up as
// the live phase dropping below last cycle's value.
module pwm_wrap_detect #(
   parameter int n = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] phase,
   output logic         wrap_c,
   output logic         wrap
);

   logic [n-1:0] phase_q;

   assign wrap_c = (phase < phase_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         wrap    <= 1'b0;
      end else begin
         phase_q <= phase;
         wrap    <= wrap_c;
      end
   end

endmodule

// File: rtl/pwm_sweep_ctrl.sv
// Triangle duty sweep LO -> HI -> LO with STEP increments, each value held for
// DWELL PWM periods; duty only updates on a period boundary.
module pwm_sweep_ctrl
   import pwm_pkg::*;
#(
   parameter int n = 14,
   parameter int m = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] phase,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [1:0]   cfg_addr,
   input  logic [m-1:0] cfg_data,
   input  logic         start,
   input  logic         stop,
   output logic [m-1:0] mod,
   output logic         busy,
   output logic         done,
   output logic         wrap
);

   localparam logic [m-1:0] ONE = {{(m-1){1'b0}}, 1'b1};

   state_t       state;
   logic [m-1:0] lo, hi, step, dwell, dcnt;
   logic [m-1:0] step_e, dwell_e, up_nxt, dn_nxt;
   logic [m:0]   up_sum;
   logic         wrap_c, dwell_hit;

   pwm_wrap_detect #(.n(n)) u_wrap (
      .clk    (clk),
      .rst    (rst),
      .phase  (phase),
      .wrap_c (wrap_c),
      .wrap   (wrap)
   );

   assign step_e  = (step  == '0) ? ONE : step;
   assign dwell_e = (dwell == '0) ? ONE : dwell;

   // Extra carry bit so a step near full scale saturates at HI instead of wrapping.
   assign up_sum    = {1'b0, mod} + {1'b0, step_e};
   assign up_nxt    = (up_sum >= {1'b0, hi}) ? hi : up_sum[m-1:0];
   assign dn_nxt    = ((mod - lo) <= step_e) ? lo : (mod - step_e);
   assign dwell_hit = (({1'b0, dcnt} + {1'b0, ONE}) >= {1'b0, dwell_e});

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lo    <= '0;
         hi    <= '1;
         step  <= ONE;
         dwell <= ONE;
         mod   <= '0;
         dcnt  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop && state != IDLE) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (cfg_valid) begin
                     case (cfg_addr)
                        ADDR_LO:   lo    <= cfg_data;
                        ADDR_HI:   hi    <= cfg_data;
                        ADDR_STEP: step  <= cfg_data;
                        default:   dwell <= cfg_data;
                     endcase
                  end
                  if (start && !stop) begin
                     state <= ARM;
                     mod   <= lo;
                  end
               end
               ARM: begin
                  if (wrap_c) begin
                     state <= UP;
                     dcnt  <= '0;
                  end
               end
               UP: begin
                  if (wrap_c) begin
                     if (dwell_hit) begin
                        dcnt <= '0;
                        if (mod >= hi) state <= DOWN;
                        else           mod   <= up_nxt;
                     end else begin
                        dcnt <= dcnt + ONE;
                     end
                  end
               end
               DOWN: begin
                  if (wrap_c) begin
                     if (dwell_hit) begin
                        dcnt <= '0;
                        if (mod <= lo) begin
                           state <= IDLE;
                           done  <= 1'b1;
                        end else begin
                           mod <= dn_nxt;
                        end
                     end else begin
                        dcnt <= dcnt + ONE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_sweep_ctrl.sv
// Directed bench for pwm_sweep_ctrl: table of sweep configs with expected duty
// per PWM period, plus hand sequences for stop, reset and config corner cases.
module tb_pwm_sweep_ctrl;
   import pwm_pkg::*;

   localparam int N = 14;
   localparam int M = 12;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] phase = '0;
   logic         cfg_valid = 1'b0;
   logic [1:0]   cfg_addr = 2'd0;
   logic [M-1:0] cfg_data = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [M-1:0] mod;
   logic         cfg_ready, busy, done, wrap;

   int checks = 0;
   int errors = 0;

   pwm_sweep_ctrl #(.n(N), .m(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .phase     (phase),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .start     (start),
      .stop      (stop),
      .mod       (mod),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   // Phase accumulator model: +1024 per cycle, wrapping every 16 cycles.
   initial forever begin
      @(posedge clk);
      #2;
      phase = phase + 14'd1024;
   end

   typedef struct packed {
      logic [11:0]      lo, hi, step, dwell;
      logic [7:0]       reps;
      logic [7:0]       nseq;
      logic [7:0][11:0] seq;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input int lo, hi, st, dw, reps, ns,
                               input int s0, s1, s2, s3, s4, s5, s6, s7);
      vec_t v;
      v.lo = lo[11:0];  v.hi = hi[11:0];  v.step = st[11:0];  v.dwell = dw[11:0];
      v.reps = reps[7:0];  v.nseq = ns[7:0];
      v.seq[0] = s0[11:0]; v.seq[1] = s1[11:0]; v.seq[2] = s2[11:0]; v.seq[3] = s3[11:0];
      v.seq[4] = s4[11:0]; v.seq[5] = s5[11:0]; v.seq[6] = s6[11:0]; v.seq[7] = s7[11:0];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [M-1:0] d);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic setup(input logic [M-1:0] lo, hi, st, dw);
      cfg_write(ADDR_LO, lo);
      cfg_write(ADDR_HI, hi);
      cfg_write(ADDR_STEP, st);
      cfg_write(ADDR_DWELL, dw);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic wait_wraps(input int k);
      int c = 0;
      int got = 0;
      while (got < k && c < 200) begin
         tick();
         c++;
         if (wrap) got++;
      end
      chk("wrap wait", 32'(got), 32'(k));
   endtask

   // Expected: each listed value seen on `reps` consecutive wrap samples, then
   // one final wrap sample holding the last value with done high.
   task automatic run_vec(input vec_t v, input int vi);
      int total, idx, cyc;
      logic [M-1:0] prev, e;
      setup(v.lo, v.hi, v.step, v.dwell);
      pulse_start();
      chk($sformatf("v%0d start mod", vi), 32'(mod), 32'(v.lo));
      chk($sformatf("v%0d start busy", vi), 32'(busy), 32'd1);
      total = v.nseq * v.reps + 1;
      idx = 0;
      cyc = 0;
      prev = mod;
      while (idx < total && cyc < 3000) begin
         tick();
         cyc++;
         chk($sformatf("v%0d change off wrap c%0d", vi, cyc),
             32'((mod !== prev || done) && !wrap), 32'd0);
         if (wrap) begin
            e = (idx < total - 1) ? v.seq[idx / v.reps] : v.seq[v.nseq - 1];
            chk($sformatf("v%0d mod w%0d", vi, idx), 32'(mod), 32'(e));
            chk($sformatf("v%0d done w%0d", vi, idx), 32'(done), 32'(idx == total - 1));
            idx++;
         end
         prev = mod;
      end
      chk($sformatf("v%0d wraps seen", vi), 32'(idx), 32'(total));
      chk($sformatf("v%0d end busy", vi), 32'(busy), 32'd0);
      chk($sformatf("v%0d end ready", vi), 32'(cfg_ready), 32'd1);
      tick();
      chk($sformatf("v%0d done one cycle", vi), 32'(done), 32'd0);
   endtask

   initial begin
      int c, p;
      logic seen_hi, bad;

      vecs[0] = mk(100, 130, 10, 1, 1, 8, 100, 110, 120, 130, 130, 120, 110, 100);
      vecs[1] = mk(100, 130, 20, 1, 1, 6, 100, 120, 130, 130, 110, 100, 0, 0);
      vecs[2] = mk(100, 130, 10, 3, 3, 8, 100, 110, 120, 130, 130, 120, 110, 100);
      vecs[3] = mk(50, 40, 10, 1, 1, 2, 50, 50, 0, 0, 0, 0, 0, 0);
      vecs[4] = mk(60, 60, 7, 1, 1, 2, 60, 60, 0, 0, 0, 0, 0, 0);
      vecs[5] = mk(10, 12, 0, 0, 1, 6, 10, 11, 12, 12, 11, 10, 0, 0);
      vecs[6] = mk(4000, 4095, 90, 1, 1, 6, 4000, 4090, 4095, 4095, 4005, 4000, 0, 0);
      vecs[7] = mk(100, 130, 25, 2, 2, 6, 100, 125, 130, 130, 105, 100, 0, 0);
      vecs[8] = mk(0, 4095, 4095, 1, 1, 4, 0, 4095, 4095, 0, 0, 0, 0, 0);

      // Reset state
      repeat (3) tick();
      chk("rst mod", 32'(mod), 32'd0);
      chk("rst cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst wrap", 32'(wrap), 32'd0);
      rst = 1'b0;

      // Wrap spacing
      c = 0;
      while (!wrap && c < 40) begin tick(); c++; end
      chk("first wrap seen", 32'(wrap), 32'd1);
      for (int k = 0; k < 2; k++) begin
         p = 0;
         do begin tick(); p++; end while (!wrap && p < 40);
         chk($sformatf("wrap period %0d", k), 32'(p), 32'd16);
      end

      // stop in IDLE is a no-op
      pulse_stop();
      chk("idle stop busy", 32'(busy), 32'd0);
      chk("idle stop ready", 32'(cfg_ready), 32'd1);

      // Defaults LO=0, HI=4095, DWELL=1: one full-scale step lands exactly on 4095
      cfg_write(ADDR_STEP, 12'd4095);
      pulse_start();
      chk("default lo", 32'(mod), 32'd0);
      wait_wraps(2);
      chk("default hi", 32'(mod), 32'd4095);
      pulse_stop();
      chk("default stop busy", 32'(busy), 32'd0);

      // stop mid-UP at 120, with start and cfg write attempted while busy
      setup(12'd100, 12'd130, 12'd10, 12'd1);
      pulse_start();
      c = 0;
      while (mod != 12'd120 && c < 400) begin tick(); c++; end
      chk("reached 120", 32'(mod), 32'd120);
      pulse_start();
      chk("start busy ignored busy", 32'(busy), 32'd1);
      chk("start busy ignored mod", 32'(mod), 32'd120);
      chk("busy cfg_ready", 32'(cfg_ready), 32'd0);
      cfg_write(ADDR_LO, 12'd5);
      pulse_stop();
      chk("stop busy", 32'(busy), 32'd0);
      chk("stop mod", 32'(mod), 32'd120);
      chk("stop done", 32'(done), 32'd0);
      bad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done || mod != 12'd120 || busy) bad = 1'b1;
      end
      chk("after stop quiet", 32'(bad), 32'd0);

      // Simultaneous start+stop in IDLE
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("start+stop busy", 32'(busy), 32'd0);
      chk("start+stop mod", 32'(mod), 32'd120);
      repeat (20) tick();
      chk("start+stop idle later", 32'(busy), 32'd0);

      // LO must not have taken the write attempted while busy
      pulse_start();
      chk("lo unchanged", 32'(mod), 32'd100);
      pulse_stop();

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Reset mid-DOWN
      setup(12'd100, 12'd130, 12'd10, 12'd1);
      pulse_start();
      c = 0;
      seen_hi = 1'b0;
      while (!(seen_hi && mod == 12'd120) && c < 600) begin
         tick();
         c++;
         if (mod == 12'd130) seen_hi = 1'b1;
      end
      chk("reached down 120", 32'(seen_hi && mod == 12'd120), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("async rst mod", 32'(mod), 32'd0);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst ready", 32'(cfg_ready), 32'd1);
      chk("async rst done", 32'(done), 32'd0);
      chk("async rst wrap", 32'(wrap), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post rst done", 32'(done), 32'd0);
      chk("post rst busy", 32'(busy), 32'd0);
      pulse_start();
      chk("post rst lo default", 32'(mod), 32'd0);
      pulse_stop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
